// File: rtl/preempt_timer_pkg.sv
// Shared constants for the preemption time-slice timer: FSM state encodings and mode values.
package preempt_timer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t COUNTING = 2'd1;
    localparam state_t PAUSED   = 2'd2;
    localparam state_t EXPIRED  = 2'd3;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into ticks, one every PRESCALE enabled cycles; frozen while enable is low.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            logic unused_ok;
            assign unused_ok = clock ^ reset ^ clear;
            assign tick      = enable;
        end else begin : g_div
            localparam int CW = $clog2(PRESCALE);
            localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

            logic [CW-1:0] count;

            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            always_ff @(posedge clock) begin
                if (reset || clear) begin
                    count <= '0;
                end else if (enable) begin
                    count <= (count == LAST) ? '0 : count + CW'(1);
                end
            end

            assign tick = enable && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/preempt_timer.sv
// Time-slice timer: counts prescaled ticks up to a run-time quantum and raises a preempt pulse,
// with one-shot/periodic modes, pause, and a pending/ack handshake that counts overruns.
module preempt_timer
    import preempt_timer_pkg::*;
#(
    parameter int WIDTH                       = 6,
    parameter logic [WIDTH-1:0] DEFAULT_QUANTUM = {WIDTH{1'b1}},
    parameter int PRESCALE                    = 1,
    parameter int OVR_WIDTH                   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 startCountSignal,
    input  logic                 stopCountSignal,
    input  logic                 pauseSignal,
    input  logic                 modeSignal,
    input  logic                 quantumLoad,
    input  logic [WIDTH-1:0]     quantumValue,
    input  logic                 preemptAck,
    output logic                 preemptSignal,
    output logic                 preemptPending,
    output logic [OVR_WIDTH-1:0] overrunCount,
    output logic [WIDTH-1:0]     counterValue,
    output logic                 busy
);

    state_t           state;
    logic [WIDTH-1:0] quantum_reg;
    logic [WIDTH-1:0] active_quantum;
    logic             mode;
    logic             tick_enable;
    logic             tick;
    logic             at_quantum;
    logic             expire;

    // PAUSED with pause released ticks on the same edge it resumes, so each paused cycle costs exactly one edge.
    assign tick_enable = !pauseSignal && (state == COUNTING || state == PAUSED);
    assign at_quantum  = (counterValue == active_quantum);
    assign expire      = tick && at_quantum && !startCountSignal && !stopCountSignal;
    assign busy        = (state == COUNTING) || (state == PAUSED);

    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .clear  (startCountSignal || stopCountSignal),
        .enable (tick_enable),
        .tick   (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            quantum_reg    <= DEFAULT_QUANTUM;
            active_quantum <= DEFAULT_QUANTUM;
            mode           <= MODE_ONESHOT;
            counterValue   <= '0;
            preemptSignal  <= 1'b0;
            preemptPending <= 1'b0;
            overrunCount   <= '0;
        end else begin
            preemptSignal <= 1'b0;

            if (quantumLoad) begin
                quantum_reg <= quantumValue;
            end

            if (stopCountSignal) begin
                state        <= IDLE;
                counterValue <= '0;
            end else if (startCountSignal) begin
                state          <= COUNTING;
                counterValue   <= '0;
                active_quantum <= quantumLoad ? quantumValue : quantum_reg;
                mode           <= modeSignal;
            end else begin
                if (state == COUNTING && pauseSignal) begin
                    state <= PAUSED;
                end else if (state == PAUSED && !pauseSignal) begin
                    state <= COUNTING;
                end

                if (expire) begin
                    counterValue  <= '0;
                    preemptSignal <= 1'b1;
                    if (mode == MODE_ONESHOT) begin
                        state <= EXPIRED;
                    end else begin
                        active_quantum <= quantum_reg;
                    end
                end else if (tick) begin
                    counterValue <= counterValue + WIDTH'(1);
                end
            end

            // A coincident ack neither clears pending nor counts as an overrun.
            if (expire) begin
                preemptPending <= 1'b1;
                if (preemptPending && !preemptAck && overrunCount != {OVR_WIDTH{1'b1}}) begin
                    overrunCount <= overrunCount + OVR_WIDTH'(1);
                end
            end else if (preemptAck) begin
                preemptPending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_preempt_timer.sv
// Directed bench for preempt_timer: a vector table for single-cycle behaviour plus hand-written
// sequences for expiry latency, prescaling, pause, overrun saturation and reset.
module tb_preempt_timer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       startCountSignal = 1'b0;
    logic       stopCountSignal = 1'b0;
    logic       pauseSignal = 1'b0;
    logic       modeSignal = 1'b0;
    logic       quantumLoad = 1'b0;
    logic [5:0] quantumValue = '0;
    logic       preemptAck = 1'b0;

    logic       p1_pulse, p1_pend, p1_busy;
    logic [3:0] p1_ovr;
    logic [5:0] p1_cnt;
    logic       p2_pulse, p2_pend, p2_busy;
    logic [3:0] p2_ovr;
    logic [5:0] p2_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    preempt_timer #(.WIDTH(6), .PRESCALE(1), .OVR_WIDTH(4)) dut (
        .clock(clock), .reset(reset),
        .startCountSignal(startCountSignal), .stopCountSignal(stopCountSignal),
        .pauseSignal(pauseSignal), .modeSignal(modeSignal),
        .quantumLoad(quantumLoad), .quantumValue(quantumValue), .preemptAck(preemptAck),
        .preemptSignal(p1_pulse), .preemptPending(p1_pend), .overrunCount(p1_ovr),
        .counterValue(p1_cnt), .busy(p1_busy)
    );

    preempt_timer #(.WIDTH(6), .PRESCALE(2), .OVR_WIDTH(4)) dut_pre2 (
        .clock(clock), .reset(reset),
        .startCountSignal(startCountSignal), .stopCountSignal(stopCountSignal),
        .pauseSignal(pauseSignal), .modeSignal(modeSignal),
        .quantumLoad(quantumLoad), .quantumValue(quantumValue), .preemptAck(preemptAck),
        .preemptSignal(p2_pulse), .preemptPending(p2_pend), .overrunCount(p2_ovr),
        .counterValue(p2_cnt), .busy(p2_busy)
    );

    typedef struct {
        logic       start, stop, pause, mode, qload;
        logic [5:0] qval;
        logic       ack;
        logic       e_pulse, e_pend, e_busy;
        logic [3:0] e_ovr;
        logic [5:0] e_cnt;
    } vec_t;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        startCountSignal = 1'b0;
        stopCountSignal  = 1'b0;
        pauseSignal      = 1'b0;
        modeSignal       = 1'b0;
        quantumLoad      = 1'b0;
        quantumValue     = '0;
        preemptAck       = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic start_timer(input logic mode, input logic load, input logic [5:0] q);
        startCountSignal = 1'b1;
        modeSignal       = mode;
        quantumLoad      = load;
        quantumValue     = q;
        step();
        clear_inputs();
    endtask

    // Steps until the selected DUT pulses; n is the number of edges taken, or -1 on timeout.
    task automatic wait_pulse(input bit use_pre2, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if ((use_pre2 ? p2_pulse : p1_pulse) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    vec_t vecs[21];

    initial begin
        int n;
        int total;

        // start, stop, pause, mode, qload, qval, ack, pulse, pend, busy, ovr, cnt
        vecs[0]  = '{1, 0, 0, 0, 1, 6'd3, 0, 0, 0, 1, 4'd0, 6'd0};
        vecs[1]  = '{0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1, 4'd0, 6'd1};
        vecs[2]  = '{0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1, 4'd0, 6'd2};
        vecs[3]  = '{0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1, 4'd0, 6'd3};
        vecs[4]  = '{0, 0, 0, 0, 0, 6'd0, 0, 1, 1, 0, 4'd0, 6'd0};
        vecs[5]  = '{0, 0, 0, 0, 0, 6'd0, 0, 0, 1, 0, 4'd0, 6'd0};
        vecs[6]  = '{0, 0, 0, 0, 0, 6'd0, 1, 0, 0, 0, 4'd0, 6'd0};
        vecs[7]  = '{1, 1, 0, 0, 0, 6'd0, 0, 0, 0, 0, 4'd0, 6'd0};
        vecs[8]  = '{1, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1, 4'd0, 6'd0};
        vecs[9]  = '{0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1, 4'd0, 6'd1};
        vecs[10] = '{0, 0, 1, 0, 0, 6'd0, 0, 0, 0, 1, 4'd0, 6'd1};
        vecs[11] = '{0, 0, 1, 0, 0, 6'd0, 0, 0, 0, 1, 4'd0, 6'd1};
        vecs[12] = '{0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1, 4'd0, 6'd2};
        vecs[13] = '{0, 1, 0, 0, 0, 6'd0, 0, 0, 0, 0, 4'd0, 6'd0};
        vecs[14] = '{1, 0, 0, 1, 1, 6'd1, 0, 0, 0, 1, 4'd0, 6'd0};
        vecs[15] = '{0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1, 4'd0, 6'd1};
        vecs[16] = '{0, 0, 0, 0, 0, 6'd0, 0, 1, 1, 1, 4'd0, 6'd0};
        vecs[17] = '{0, 0, 0, 0, 0, 6'd0, 0, 0, 1, 1, 4'd0, 6'd1};
        vecs[18] = '{0, 0, 0, 0, 0, 6'd0, 0, 1, 1, 1, 4'd1, 6'd0};
        vecs[19] = '{0, 0, 0, 0, 0, 6'd0, 1, 0, 0, 1, 4'd1, 6'd1};
        vecs[20] = '{0, 1, 0, 0, 0, 6'd0, 0, 0, 0, 0, 4'd1, 6'd0};

        // Reset state on both instances.
        do_reset();
        check("reset_pulse", p1_pulse, 0);
        check("reset_pend", p1_pend, 0);
        check("reset_busy", p1_busy, 0);
        check("reset_ovr", p1_ovr, 0);
        check("reset_cnt", p1_cnt, 0);
        check("reset_pre2_busy", p2_busy, 0);

        // Table-driven single-cycle behaviour, PRESCALE=1.
        for (int i = 0; i < 21; i++) begin
            startCountSignal = vecs[i].start;
            stopCountSignal  = vecs[i].stop;
            pauseSignal      = vecs[i].pause;
            modeSignal       = vecs[i].mode;
            quantumLoad      = vecs[i].qload;
            quantumValue     = vecs[i].qval;
            preemptAck       = vecs[i].ack;
            step();
            check($sformatf("vec%0d_pulse", i), p1_pulse, vecs[i].e_pulse);
            check($sformatf("vec%0d_pend", i), p1_pend, vecs[i].e_pend);
            check($sformatf("vec%0d_busy", i), p1_busy, vecs[i].e_busy);
            check($sformatf("vec%0d_ovr", i), p1_ovr, vecs[i].e_ovr);
            check($sformatf("vec%0d_cnt", i), p1_cnt, vecs[i].e_cnt);
        end
        clear_inputs();

        // Default quantum one-shot: pulse exactly 64 edges after start.
        do_reset();
        start_timer(1'b0, 1'b0, 6'd0);
        check("default_start_cnt", p1_cnt, 0);
        check("default_start_busy", p1_busy, 1);
        wait_pulse(1'b0, 100, n);
        check("default_latency", n, 64);
        check("default_exp_busy", p1_busy, 0);
        check("default_exp_pend", p1_pend, 1);
        check("default_exp_cnt", p1_cnt, 0);
        step();
        check("default_pulse_one_cycle", p1_pulse, 0);
        check("default_expired_cnt", p1_cnt, 0);

        // Restart while counter = 30: back to 0, no pulse, full latency again.
        preemptAck = 1'b1;
        step();
        preemptAck = 1'b0;
        start_timer(1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 30; i++) step();
        check("restart_cnt30", p1_cnt, 30);
        start_timer(1'b0, 1'b0, 6'd0);
        check("restart_cnt0", p1_cnt, 0);
        check("restart_no_pulse", p1_pulse, 0);
        wait_pulse(1'b0, 100, n);
        check("restart_latency", n, 64);

        // PRESCALE=2 periodic with Q=5: 12-cycle period; reload 9 gives a 20-cycle period next.
        do_reset();
        start_timer(1'b1, 1'b1, 6'd5);
        wait_pulse(1'b1, 100, n);
        check("pre2_first", n, 12);
        wait_pulse(1'b1, 100, n);
        check("pre2_period", n, 12);
        check("pre2_periodic_busy", p2_busy, 1);
        quantumLoad  = 1'b1;
        quantumValue = 6'd9;
        step();
        clear_inputs();
        check("pre2_after_pulse", p2_pulse, 0);
        wait_pulse(1'b1, 100, n);
        check("pre2_period_before_reload", n + 1, 12);
        wait_pulse(1'b1, 100, n);
        check("pre2_period_reloaded", n, 20);
        stopCountSignal = 1'b1;
        step();
        clear_inputs();
        check("pre2_stop_busy", p2_busy, 0);
        check("pre2_stop_keeps_pend", p2_pend, 1);

        // Pause 7 cycles during a Q=10 one-shot count: expiry at 11 + 7 edges.
        do_reset();
        start_timer(1'b0, 1'b1, 6'd10);
        total = 0;
        for (int i = 0; i < 3; i++) step();
        total += 3;
        pauseSignal = 1'b1;
        for (int i = 0; i < 7; i++) step();
        total += 7;
        check("pause_frozen_cnt", p1_cnt, 3);
        check("pause_busy", p1_busy, 1);
        pauseSignal = 1'b0;
        wait_pulse(1'b0, 100, n);
        check("pause_latency", (n < 0) ? -1 : total + n, 18);

        // Pause on the expiry tick suppresses expiry until resumed.
        start_timer(1'b0, 1'b1, 6'd2);
        step();
        step();
        check("pause_exp_cnt", p1_cnt, 2);
        pauseSignal = 1'b1;
        step();
        check("pause_exp_no_pulse", p1_pulse, 0);
        check("pause_exp_hold_cnt", p1_cnt, 2);
        pauseSignal = 1'b0;
        step();
        check("pause_exp_resume_pulse", p1_pulse, 1);

        // Q=0 periodic: expiry every edge; coincident ack holds pending and count; then saturation.
        do_reset();
        start_timer(1'b1, 1'b1, 6'd0);
        for (int i = 0; i < 3; i++) step();
        check("q0_ovr_after3", p1_ovr, 2);
        check("q0_pulse", p1_pulse, 1);
        preemptAck = 1'b1;
        step();
        preemptAck = 1'b0;
        check("ack_coincident_pend", p1_pend, 1);
        check("ack_coincident_ovr", p1_ovr, 2);
        for (int i = 0; i < 20; i++) step();
        check("ovr_saturated", p1_ovr, 15);
        check("ovr_pend", p1_pend, 1);
        stopCountSignal = 1'b1;
        step();
        clear_inputs();
        check("ovr_kept_on_stop", p1_ovr, 15);

        // Reset on the would-be expiry edge: pulse dropped, everything cleared, quantum back to 63.
        start_timer(1'b0, 1'b1, 6'd4);
        for (int i = 0; i < 4; i++) step();
        check("rst_pre_cnt", p1_cnt, 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_no_pulse", p1_pulse, 0);
        check("rst_pend", p1_pend, 0);
        check("rst_ovr", p1_ovr, 0);
        check("rst_cnt", p1_cnt, 0);
        check("rst_busy", p1_busy, 0);
        step();
        check("rst_still_no_pulse", p1_pulse, 0);
        start_timer(1'b0, 1'b0, 6'd0);
        wait_pulse(1'b0, 100, n);
        check("rst_quantum_63", n, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
